frame_sync_pio: RTL and testbench
=================================

// Module: frame_sync_pio
// PURPOSE
//  Avalon-MM slave output port whose value is held in a shadow register and applied only at a
//  video frame boundary: the accepted start-of-packet beat on a monitored stream.
//  Drives the video-path router select without mid-frame switching.
//  Generalises the single-bit router PIO: width, immediate mode, set/clear, timeout, IRQ.
//  Sits beside the edge-detection router; snoops that router's input stream handshake only.
// PARAMETERS
//  DATA_WIDTH      1     width of out_port / shadow / active registers (1..32)
//  RESET_VALUE     0     value of shadow and active after reset (DATA_WIDTH bits)
//  TIMEOUT_CYCLES  0     cycles a pending update waits for SOP before forced apply; 0 = never
// PORTS
//  clk                 in   1   system clock
//  reset               in   1   synchronous, active-high reset
//  address             in   3   register select
//  chipselect          in   1   slave select
//  read                in   1   read strobe
//  write               in   1   write strobe
//  writedata           in   32  write data; bits above DATA_WIDTH ignored
//  readdata            out  32  read data, zero-extended
//  stream_valid        in   1   monitored stream valid
//  stream_ready        in   1   monitored stream ready
//  stream_sop          in   1   monitored stream startofpacket
//  out_port            out  DW  active value
//  update_strobe       out  1   one-cycle pulse in the cycle after active changes source
//  irq                 out  1   level interrupt
// BEHAVIOUR
//  Reset: shadow = active = RESET_VALUE; pending = 0; ctrl = 0; applied_sticky = 0;
//   timeout counter = 0; update_strobe = 0; irq = 0; out_port = RESET_VALUE.
//  Register map (wr = chipselect & write):
//   0 DATA     R: active         W: shadow <= wd; pending <= 1
//   1 SHADOW   R: shadow         W: ignored
//   2 CONTROL  R/W: bit0 IMMEDIATE, bit1 IRQ_EN
//   3 STATUS   R: bit0 pending, bit1 applied_sticky   W: 1 to bit1 clears sticky
//   4 OUTSET   R: 0              W: shadow <= shadow | wd; pending <= 1
//   5 OUTCLEAR R: 0              W: shadow <= shadow & ~wd; pending <= 1
//   6,7        R: 0              W: ignored
//  Reads: readdata combinational from address; read latency 0; reads have no side effects.
//  Boundary event: sop_evt = stream_valid & stream_ready & stream_sop.
//  Apply condition, evaluated each cycle: pending & (sop_evt | timeout_hit | IMMEDIATE).
//   On apply: active <= shadow (registered value, before this cycle's write);
//   pending <= 0; applied_sticky <= 1; update_strobe <= 1 next cycle.
//   Active therefore changes on the SOP beat edge; the SOP beat sees the old value in that cycle.
//  Same-cycle host write and apply: apply uses old shadow; write updates shadow and pending
//   ends at 1 (write wins over clear).
//  IMMEDIATE=1: a write to 0/4/5 applies in the following cycle, independent of the stream.
//  Timeout (TIMEOUT_CYCLES>0): counter increments while pending & ~apply.
//   Counter resets to 0 on apply or on any write to 0/4/5.
//   timeout_hit = (counter == TIMEOUT_CYCLES-1).
//  Counter width is $clog2(TIMEOUT_CYCLES+1); it saturates and never wraps.
//  irq = IRQ_EN & applied_sticky, registered. Sticky stays set until cleared by software.
//  Clearing the sticky in the same cycle as an apply leaves it set (set wins).
//  Reset mid-frame or while pending discards the pending update. Stream inputs are never driven.
// STRUCTURE
//  Shared package frame_sync_pio_pkg:
//   register address constants ADDR_DATA..ADDR_OUTCLEAR
//   CONTROL and STATUS bit indices
//  Sub-module: frame_sync_timeout (counter + hit flag; params TIMEOUT_CYCLES).
//   Generated out when TIMEOUT_CYCLES==0.
//  Top level holds the register file, apply logic and read mux.
// TESTING
//  1 DW=1: write DATA=1 with no SOP for 100 cycles
//    -> out_port stays 0, STATUS=0x1.
//    Then one sop_evt -> out_port=1 on the next edge, update_strobe pulses once, STATUS=0x2.
//  2 DW=8, shadow=0xF0: OUTSET 0x0F, then OUTCLEAR 0x81, then SOP
//    -> SHADOW reads 0x7E, out_port=0x7E.
//  3 Same-cycle: DATA=0x5 pending; in the cycle of a sop_evt, write DATA=0xA
//    -> out_port=0x5, pending=1. Next SOP -> out_port=0xA.
//  4 TIMEOUT_CYCLES=16, no stream activity: write DATA=3
//    -> out_port=3 exactly 16 cycles after the write; strobe pulses once.
//  5 IMMEDIATE=1, IRQ_EN=1: write DATA=1 -> out_port=1 in the next cycle; irq rises 1 cycle later.
//    Write STATUS=0x2 -> irq falls.
//  6 Pending DATA=1, assert reset for one cycle -> out_port=RESET_VALUE; later SOP has no effect.

Source files
------------

// File: rtl/frame_sync_pio_pkg.sv
// Shared register map and bit positions for the frame-synchronised output port.
package frame_sync_pio_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_SHADOW   = 3'd1;
  localparam logic [2:0] ADDR_CONTROL  = 3'd2;
  localparam logic [2:0] ADDR_STATUS   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

  localparam int CTRL_IMMEDIATE = 0;
  localparam int CTRL_IRQ_EN    = 1;
  localparam int STAT_PENDING   = 0;
  localparam int STAT_STICKY    = 1;

  // Addresses whose writes modify the shadow and arm a pending update.
  function automatic logic is_update_addr(input logic [2:0] a);
    return (a == ADDR_DATA) || (a == ADDR_OUTSET) || (a == ADDR_OUTCLEAR);
  endfunction

endpackage

// File: rtl/frame_sync_timeout.sv
// Counts cycles a pending update has waited for a frame boundary; flags when the limit is reached.
module frame_sync_timeout #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic pending,
  input  logic apply,
  input  logic restart,
  output logic hit
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;

  // Saturating: a stuck count is preferable to wrapping back below the limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (restart || apply) begin
      count <= '0;
    end else if (pending && (count != {CW{1'b1}})) begin
      count <= count + CW'(1);
    end
  end

  assign hit = (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/frame_sync_pio.sv
// Avalon-MM output port whose written value reaches out_port only at a video frame boundary.
module frame_sync_pio
  import frame_sync_pio_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 1,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE    = '0,
  parameter int                    TIMEOUT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  read,
  input  logic                  write,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic                  stream_valid,
  input  logic                  stream_ready,
  input  logic                  stream_sop,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  update_strobe,
  output logic                  irq
);

  logic [DATA_WIDTH-1:0] shadow, active, shadow_next, wd;
  logic [1:0]            ctrl;
  logic                  pending, sticky, strobe_q, irq_q;
  logic                  wr, upd_wr, sop_evt, timeout_hit, apply;
  logic                  unused_bits;

  assign wd          = writedata[DATA_WIDTH-1:0];
  assign wr          = chipselect & write;
  assign upd_wr      = wr & is_update_addr(address);
  assign unused_bits = ^{writedata, read};

  // Stream handshake: a beat transfers only in a cycle where stream_valid and
  // stream_ready are both high; the SOP flag of a transferred beat is the frame boundary.
  assign sop_evt = stream_valid & stream_ready & stream_sop;
  assign apply   = pending & (sop_evt | timeout_hit | ctrl[CTRL_IMMEDIATE]);

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_timeout
      frame_sync_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .pending (pending),
        .apply   (apply),
        .restart (upd_wr),
        .hit     (timeout_hit)
      );
    end else begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end
  endgenerate

  always_comb begin
    shadow_next = shadow;
    if (wr) begin
      case (address)
        ADDR_DATA:     shadow_next = wd;
        ADDR_OUTSET:   shadow_next = shadow | wd;
        ADDR_OUTCLEAR: shadow_next = shadow & ~wd;
        default:       shadow_next = shadow;
      endcase
    end
  end

  // Apply copies the registered shadow, so a same-cycle write lands in the next update.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow   <= RESET_VALUE;
      active   <= RESET_VALUE;
      pending  <= 1'b0;
      ctrl     <= 2'b00;
      sticky   <= 1'b0;
      strobe_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      shadow   <= shadow_next;
      strobe_q <= apply;
      irq_q    <= ctrl[CTRL_IRQ_EN] & sticky;
      if (apply) active <= shadow;
      if (upd_wr)     pending <= 1'b1;
      else if (apply) pending <= 1'b0;
      if (wr && (address == ADDR_CONTROL)) ctrl <= writedata[1:0];
      if (apply) sticky <= 1'b1;
      else if (wr && (address == ADDR_STATUS) && writedata[STAT_STICKY]) sticky <= 1'b0;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata = 32'(active);
      ADDR_SHADOW:  readdata = 32'(shadow);
      ADDR_CONTROL: readdata[1:0] = ctrl;
      ADDR_STATUS: begin
        readdata[STAT_PENDING] = pending;
        readdata[STAT_STICKY]  = sticky;
      end
      default:      readdata = '0;
    endcase
  end

  assign out_port      = active;
  assign update_strobe = strobe_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_frame_sync_pio.sv
// Bench for frame_sync_pio: an 8-bit no-timeout instance and a 4-bit instance with a 16-cycle timeout.
module tb_frame_sync_pio;
  import frame_sync_pio_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0, read = 1'b0, write = 1'b0;
  logic [31:0] writedata = '0;
  logic        stream_valid = 1'b0, stream_ready = 1'b0, stream_sop = 1'b0;
  logic        sel = 1'b0;
  logic [31:0] rd_a, rd_t, readdata;
  logic [7:0]  out_a;
  logic [3:0]  out_t;
  logic        strobe_a, strobe_t, irq_a, irq_t;
  logic        cs_a, cs_t, sv_a, sv_t;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign cs_a     = chipselect & ~sel;
  assign cs_t     = chipselect & sel;
  assign sv_a     = stream_valid & ~sel;
  assign sv_t     = stream_valid & sel;
  assign readdata = sel ? rd_t : rd_a;

  frame_sync_pio #(.DATA_WIDTH(8), .RESET_VALUE(8'h00), .TIMEOUT_CYCLES(0)) u_dut_a (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs_a), .read(read),
    .write(write), .writedata(writedata), .readdata(rd_a), .stream_valid(sv_a),
    .stream_ready(stream_ready), .stream_sop(stream_sop), .out_port(out_a),
    .update_strobe(strobe_a), .irq(irq_a)
  );

  frame_sync_pio #(.DATA_WIDTH(4), .RESET_VALUE(4'h9), .TIMEOUT_CYCLES(16)) u_dut_t (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs_t), .read(read),
    .write(write), .writedata(writedata), .readdata(rd_t), .stream_valid(sv_t),
    .stream_ready(stream_ready), .stream_sop(stream_sop), .out_port(out_t),
    .update_strobe(strobe_t), .irq(irq_t)
  );

  // ---------------- reference model for the 8-bit instance ----------------
  typedef struct {
    logic [7:0] shadow;
    logic [7:0] active;
    logic       pending;
    logic       immediate;
    logic       irq_en;
    logic       sticky;
    logic       strobe;
    logic       irq;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t s;
    s.shadow = 8'h00; s.active = 8'h00; s.pending = 1'b0; s.immediate = 1'b0;
    s.irq_en = 1'b0; s.sticky = 1'b0; s.strobe = 1'b0; s.irq = 1'b0;
    return s;
  endfunction

  function automatic logic [31:0] model_read(model_t s, logic [2:0] a);
    if (a == 3'd0) return {24'h0, s.active};
    if (a == 3'd1) return {24'h0, s.shadow};
    if (a == 3'd2) return {30'h0, s.irq_en, s.immediate};
    if (a == 3'd3) return {30'h0, s.sticky, s.pending};
    return 32'h0;
  endfunction

  function automatic model_t model_step(model_t s, logic cs, logic we, logic [2:0] a,
                                        logic [31:0] d, logic v, logic r, logic sop);
    model_t n = s;
    logic   host_wr = cs && we;
    logic   take = s.pending && ((v && r && sop) || s.immediate);
    n.strobe = take;
    n.irq    = s.irq_en && s.sticky;
    if (take) begin
      n.active  = s.shadow;
      n.pending = 1'b0;
      n.sticky  = 1'b1;
    end else if (host_wr && a == 3'd3 && d[1]) begin
      n.sticky = 1'b0;
    end
    if (host_wr && a == 3'd0) begin n.shadow = d[7:0];              n.pending = 1'b1; end
    if (host_wr && a == 3'd4) begin n.shadow = s.shadow | d[7:0];   n.pending = 1'b1; end
    if (host_wr && a == 3'd5) begin n.shadow = s.shadow & ~d[7:0];  n.pending = 1'b1; end
    if (host_wr && a == 3'd2) begin n.immediate = d[0]; n.irq_en = d[1]; end
    return n;
  endfunction

  // ---------------- table of directed vectors (8-bit instance) ----------------
  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] wd;
    logic [2:0]  strm;     // {valid, ready, sop}
    logic [2:0]  rd_addr;
    logic [31:0] exp_rd;
    logic [7:0]  exp_out;
  } vec_t;

  vec_t vecs[20];

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic sop_beat();
    {stream_valid, stream_ready, stream_sop} = 3'b111;
    @(negedge clk);
    {stream_valid, stream_ready, stream_sop} = 3'b000;
  endtask

  task automatic rd_check(input string name, input logic [2:0] a, input logic [31:0] exp);
    address = a; chipselect = 1'b1; read = 1'b1;
    #1;
    check(name, readdata, exp);
    chipselect = 1'b0; read = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt, pulses;
    logic moved;

    vecs[0]  = '{1'b1, ADDR_DATA,     32'hF0,  3'b000, ADDR_SHADOW,  32'hF0, 8'h00};
    vecs[1]  = '{1'b0, ADDR_DATA,     32'h0,   3'b111, ADDR_STATUS,  32'h2,  8'hF0};
    vecs[2]  = '{1'b1, ADDR_OUTSET,   32'h0F,  3'b000, ADDR_SHADOW,  32'hFF, 8'hF0};
    vecs[3]  = '{1'b1, ADDR_OUTCLEAR, 32'h81,  3'b000, ADDR_SHADOW,  32'h7E, 8'hF0};
    vecs[4]  = '{1'b0, ADDR_DATA,     32'h0,   3'b000, ADDR_STATUS,  32'h3,  8'hF0};
    vecs[5]  = '{1'b0, ADDR_DATA,     32'h0,   3'b111, ADDR_DATA,    32'h7E, 8'h7E};
    vecs[6]  = '{1'b1, ADDR_DATA,     32'h05,  3'b000, ADDR_STATUS,  32'h3,  8'h7E};
    vecs[7]  = '{1'b1, ADDR_DATA,     32'h0A,  3'b111, ADDR_STATUS,  32'h3,  8'h05};
    vecs[8]  = '{1'b0, ADDR_DATA,     32'h0,   3'b111, ADDR_DATA,    32'h0A, 8'h0A};
    vecs[9]  = '{1'b1, ADDR_STATUS,   32'h2,   3'b000, ADDR_STATUS,  32'h0,  8'h0A};
    vecs[10] = '{1'b1, ADDR_DATA,     32'h1FF, 3'b000, ADDR_SHADOW,  32'hFF, 8'h0A};
    vecs[11] = '{1'b1, 3'd6,          32'h55,  3'b000, ADDR_SHADOW,  32'hFF, 8'h0A};
    vecs[12] = '{1'b1, ADDR_SHADOW,   32'h11,  3'b000, ADDR_SHADOW,  32'hFF, 8'h0A};
    vecs[13] = '{1'b0, ADDR_DATA,     32'h0,   3'b000, ADDR_OUTSET,  32'h0,  8'h0A};
    vecs[14] = '{1'b0, ADDR_DATA,     32'h0,   3'b000, 3'd7,         32'h0,  8'h0A};
    vecs[15] = '{1'b1, ADDR_CONTROL,  32'h2,   3'b000, ADDR_CONTROL, 32'h2,  8'h0A};
    vecs[16] = '{1'b1, ADDR_CONTROL,  32'h0,   3'b000, ADDR_CONTROL, 32'h0,  8'h0A};
    vecs[17] = '{1'b0, ADDR_DATA,     32'h0,   3'b101, ADDR_STATUS,  32'h1,  8'h0A};
    vecs[18] = '{1'b0, ADDR_DATA,     32'h0,   3'b110, ADDR_STATUS,  32'h1,  8'h0A};
    vecs[19] = '{1'b0, ADDR_DATA,     32'h0,   3'b111, ADDR_STATUS,  32'h2,  8'hFF};

    // ---- reset state ----
    @(negedge clk);
    do_reset();
    check("reset_out_a", out_a, 32'h00);
    check("reset_out_t", out_t, 32'h9);
    check("reset_strobe", {strobe_a, strobe_t}, 32'h0);
    check("reset_irq", {irq_a, irq_t}, 32'h0);
    rd_check("reset_status_a", ADDR_STATUS, 32'h0);
    sel = 1'b1;
    rd_check("reset_data_t", ADDR_DATA, 32'h9);
    sel = 1'b0;

    // ---- held update with no boundary for 100 cycles ----
    bus_write(ADDR_DATA, 32'h1);
    moved = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (out_a !== 8'h00 || strobe_a !== 1'b0) moved = 1'b1;
      @(negedge clk);
    end
    check("hold_no_sop", {31'h0, moved}, 32'h0);
    rd_check("hold_status", ADDR_STATUS, 32'h1);
    sop_beat();
    check("sop_apply_out", out_a, 32'h01);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (strobe_a) pulses++;
      @(negedge clk);
    end
    check("sop_strobe_pulses", pulses, 32'd1);
    rd_check("sop_status", ADDR_STATUS, 32'h2);

    // ---- directed table ----
    do_reset();
    for (int i = 0; i < 20; i++) begin
      chipselect = vecs[i].wr; write = vecs[i].wr;
      address = vecs[i].addr; writedata = vecs[i].wd;
      {stream_valid, stream_ready, stream_sop} = vecs[i].strm;
      @(negedge clk);
      chipselect = 1'b0; write = 1'b0;
      {stream_valid, stream_ready, stream_sop} = 3'b000;
      rd_check($sformatf("vec%0d_rd", i), vecs[i].rd_addr, vecs[i].exp_rd);
      check($sformatf("vec%0d_out", i), out_a, {24'h0, vecs[i].exp_out});
    end

    // ---- immediate mode and interrupt ----
    bus_write(ADDR_STATUS, 32'h2);
    bus_write(ADDR_CONTROL, 32'h3);
    bus_write(ADDR_DATA, 32'h3C);
    check("imm_not_yet", out_a, 32'hFF);
    @(negedge clk);
    check("imm_applied", out_a, 32'h3C);
    check("imm_irq_low", irq_a, 32'h0);
    @(negedge clk);
    check("imm_irq_high", irq_a, 32'h1);
    bus_write(ADDR_STATUS, 32'h2);
    check("irq_still_high", irq_a, 32'h1);
    @(negedge clk);
    check("irq_cleared", irq_a, 32'h0);
    bus_write(ADDR_DATA, 32'h11);
    bus_write(ADDR_STATUS, 32'h2);
    rd_check("set_wins_status", ADDR_STATUS, 32'h2);
    check("set_wins_out", out_a, 32'h11);
    @(negedge clk);
    check("set_wins_irq", irq_a, 32'h1);
    bus_write(ADDR_CONTROL, 32'h0);

    // ---- forced apply after 16 cycles without a boundary ----
    sel = 1'b1;
    bus_write(ADDR_DATA, 32'h3);
    cnt = 0; pulses = 0;
    while (out_t !== 4'h3 && cnt < 40) begin
      @(negedge clk);
      cnt++;
      if (strobe_t) pulses++;
    end
    check("timeout_cycles", cnt, 32'd16);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (strobe_t) pulses++;
    end
    check("timeout_strobe_pulses", pulses, 32'd1);
    rd_check("timeout_status", ADDR_STATUS, 32'h2);

    // ---- reset discards a pending update ----
    bus_write(ADDR_DATA, 32'h2);
    do_reset();
    check("rst_pend_out_t", out_t, 32'h9);
    rd_check("rst_pend_status_t", ADDR_STATUS, 32'h0);
    sop_beat();
    for (int i = 0; i < 30; i++) @(negedge clk);
    check("rst_pend_after_sop", out_t, 32'h9);
    sel = 1'b0;

    // ---- randomized traffic against the model ----
    do_reset();
    m = model_reset();
    for (int i = 0; i < 400; i++) begin
      chipselect   = ($urandom_range(0, 1) == 1);
      write        = ($urandom_range(0, 3) == 0);
      read         = chipselect & ~write;
      address      = 3'($urandom_range(0, 7));
      writedata    = $urandom;
      stream_valid = ($urandom_range(0, 1) == 1);
      stream_ready = ($urandom_range(0, 1) == 1);
      stream_sop   = ($urandom_range(0, 2) == 0);
      #1;
      check("rand_out", out_a, {24'h0, m.active});
      check("rand_strobe", strobe_a, {31'h0, m.strobe});
      check("rand_irq", irq_a, {31'h0, m.irq});
      check("rand_rd", readdata, model_read(m, address));
      m = model_step(m, chipselect, write, address, writedata,
                     stream_valid, stream_ready, stream_sop);
      @(negedge clk);
    end
    chipselect = 1'b0; write = 1'b0; read = 1'b0;
    {stream_valid, stream_ready, stream_sop} = 3'b000;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
